fpu_addsub_sched: RTL and testbench

//  Round-robin scheduler that shares one pipelined FP add/sub unit among NUM_REQ

---
 rtl/fpu_addsub_sched_pkg.sv | 20 ++
 rtl/fpu_addsub_sched_if.sv | 37 +++
 rtl/fpu_addsub_sched_rr_arbiter.sv | 30 +++
 rtl/fpu_addsub_sched.sv | 127 ++++++++++++
 tb/tb_fpu_addsub_sched.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_addsub_sched_pkg.sv
// Shared types and default sizing for the FP add/sub scheduler and the FPU wrapper.
package fpu_sched_pkg;

  localparam int FPU_NUM_REQ = 4;
  localparam int FPU_DATA_W  = 32;
  localparam int FPU_LAT     = 3;
  localparam int FPU_IDX_W   = $clog2(FPU_NUM_REQ);

  typedef struct packed {
    logic [FPU_DATA_W-1:0] a;
    logic [FPU_DATA_W-1:0] b;
    logic                  sub;
  } fpu_req_t;

  typedef struct packed {
    logic                 vld;
    logic [FPU_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/fpu_addsub_sched_if.sv
// Requester, FPU issue/result and response bundle for fpu_addsub_sched.
interface fpu_addsub_sched_if
  import fpu_sched_pkg::*;
#(
  parameter int NUM_REQ = FPU_NUM_REQ,
  parameter int DATA_W  = FPU_DATA_W
);

  logic [NUM_REQ-1:0]             i_req_valid;
  logic [NUM_REQ-1:0]             o_req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] i_req_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] i_req_b;
  logic [NUM_REQ-1:0]             i_req_sub;

  logic                           o_fpu_valid;
  logic [DATA_W-1:0]              o_fpu_a;
  logic [DATA_W-1:0]              o_fpu_b;
  logic                           o_fpu_sub;
  logic [DATA_W-1:0]              i_fpu_result;

  logic [NUM_REQ-1:0]             o_rsp_valid;
  logic [DATA_W-1:0]              o_rsp_data;
  logic                           o_busy;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_req_sub, i_fpu_result,
    output o_req_ready, o_fpu_valid, o_fpu_a, o_fpu_b, o_fpu_sub,
           o_rsp_valid, o_rsp_data, o_busy
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_req_sub, i_fpu_result,
    input  o_req_ready, o_fpu_valid, o_fpu_a, o_fpu_b, o_fpu_sub,
           o_rsp_valid, o_rsp_data, o_busy
  );

endinterface

// File: rtl/fpu_addsub_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_sched.sv
// Round-robin sharing of one pipelined FP add/sub among NUM_REQ requesters.
// Optional FPU_SCHED_PERF_EN adds o_issue_cnt / o_stall_cnt.
module fpu_addsub_sched
  import fpu_sched_pkg::*;
#(
  parameter int NUM_REQ = FPU_NUM_REQ,
  parameter int DATA_W  = FPU_DATA_W,
  parameter int LAT     = FPU_LAT
) (
  input  logic                i_clk,
  input  logic                i_rst,
`ifdef FPU_SCHED_PERF_EN
  output logic [31:0]         o_issue_cnt,
  output logic [31:0]         o_stall_cnt,
`endif
  fpu_addsub_sched_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               xfer;

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  fpu_req_t           req_q, req_d;
  tag_t [LAT:0]       tag_q, tag_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               busy;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i (bus.i_req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Grant is masked during reset so every output reads zero while it is held.
  assign xfer            = gnt_any & ~i_rst;
  assign bus.o_req_ready = i_rst ? '0 : gnt;

  always_comb begin
    ptr_d = ptr_q;
    req_d = req_q;
    if (xfer) begin
      ptr_d     = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      req_d.a   = bus.i_req_a[gnt_idx];
      req_d.b   = bus.i_req_b[gnt_idx];
      req_d.sub = bus.i_req_sub[gnt_idx];
    end
  end

  // Stage 0 is the issue register; stage LAT lines up with the FPU result.
  always_comb begin
    tag_d[0].vld = xfer;
    tag_d[0].idx = FPU_IDX_W'(gnt_idx);
    for (int i = 1; i <= LAT; i++) tag_d[i] = tag_q[i-1];
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_q[LAT].vld) begin
      rsp_valid_d[tag_q[LAT].idx] = 1'b1;
      rsp_data_d                  = bus.i_fpu_result;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q       <= '0;
      req_q       <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      req_q       <= req_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    busy = |rsp_valid_q;
    for (int i = 0; i <= LAT; i++) busy = busy | tag_q[i].vld;
  end

  assign bus.o_fpu_valid = tag_q[0].vld;
  assign bus.o_fpu_a     = req_q.a;
  assign bus.o_fpu_b     = req_q.b;
  assign bus.o_fpu_sub   = req_q.sub;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_busy      = busy;

`ifdef FPU_SCHED_PERF_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q + 32'(xfer);
    stall_cnt_d = stall_cnt_q + 32'(|(bus.i_req_valid & ~gnt));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_issue_cnt = issue_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_addsub_sched.sv
// Directed bench for fpu_addsub_sched with a cycle-indexed expectation model.
module tb_fpu_addsub_sched;
  import fpu_sched_pkg::*;

  localparam int NR  = FPU_NUM_REQ;
  localparam int LAT = FPU_LAT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_addsub_sched_if bus ();

`ifdef FPU_SCHED_PERF_EN
  logic [31:0] issue_cnt, stall_cnt;
`endif

  fpu_addsub_sched dut (
    .i_clk       (clk),
    .i_rst       (rst),
`ifdef FPU_SCHED_PERF_EN
    .o_issue_cnt (issue_cnt),
    .o_stall_cnt (stall_cnt),
`endif
    .bus         (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Stand-in FPU: 1.0 + 2.0 gives the real answer, everything else a scrambled pattern.
  function automatic logic [31:0] fmod(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !s) return 32'h4040_0000;
    return (a ^ {b[7:0], b[31:8]}) + {31'b0, s};
  endfunction

  logic [31:0] fpu_pipe [LAT];
  always @(posedge clk) begin
    fpu_pipe[0] <= fmod(bus.o_fpu_a, bus.o_fpu_b, bus.o_fpu_sub);
    for (int k = 1; k < LAT; k++) fpu_pipe[k] <= fpu_pipe[k-1];
  end
  assign bus.i_fpu_result = fpu_pipe[LAT-1];

  function automatic logic [NR-1:0] mgrant(input logic [NR-1:0] v, input int p, output int k);
    mgrant = '0;
    k = -1;
    for (int j = 0; j < NR; j++) begin
      int c;
      c = (p + j) % NR;
      if (k < 0 && v[c]) begin
        k = c;
        mgrant[c] = 1'b1;
      end
    end
  endfunction

  // Expectations indexed by cycle number modulo 64.
  logic          ex_fv [64];
  logic [31:0]   ex_fa [64];
  logic [31:0]   ex_fb [64];
  logic          ex_fs [64];
  logic [NR-1:0] ex_rv [64];
  logic [31:0]   ex_rd [64];

  initial begin
    int cyc, s, n, r, k, m_ptr;
    logic [NR-1:0] eg;
    logic [31:0] la, lb;
    logic ls, eb;
`ifdef FPU_SCHED_PERF_EN
    logic [31:0] m_iss, m_stl;
    m_iss = 0; m_stl = 0;
`endif
    cyc = 0; m_ptr = 0; la = 0; lb = 0; ls = 0;
    for (int i = 0; i < 64; i++) begin ex_fv[i] = 0; ex_rv[i] = '0; end
    forever begin
      @(negedge clk);
      s = cyc % 64;
      if (rst) begin
        chk("rst_ready", bus.o_req_ready, 0);
        chk("rst_fpu_valid", bus.o_fpu_valid, 0);
        chk("rst_fpu_a", bus.o_fpu_a, 0);
        chk("rst_fpu_b", bus.o_fpu_b, 0);
        chk("rst_fpu_sub", bus.o_fpu_sub, 0);
        chk("rst_rsp_valid", bus.o_rsp_valid, 0);
        chk("rst_rsp_data", bus.o_rsp_data, 0);
        chk("rst_busy", bus.o_busy, 0);
        for (int i = 0; i < 64; i++) begin ex_fv[i] = 0; ex_rv[i] = '0; end
        m_ptr = 0; la = 0; lb = 0; ls = 0;
`ifdef FPU_SCHED_PERF_EN
        chk("rst_issue_cnt", issue_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        m_iss = 0; m_stl = 0;
`endif
      end else begin
        eg = mgrant(bus.i_req_valid, m_ptr, k);
        chk("ready", bus.o_req_ready, eg);
        chk("fpu_valid", bus.o_fpu_valid, ex_fv[s]);
        if (ex_fv[s]) begin la = ex_fa[s]; lb = ex_fb[s]; ls = ex_fs[s]; end
        chk("fpu_a", bus.o_fpu_a, la);
        chk("fpu_b", bus.o_fpu_b, lb);
        chk("fpu_sub", bus.o_fpu_sub, ls);
        chk("rsp_valid", bus.o_rsp_valid, ex_rv[s]);
        if (ex_rv[s] != '0) chk("rsp_data", bus.o_rsp_data, ex_rd[s]);
        eb = 0;
        for (int j = 0; j <= LAT + 1; j++)
          if (cyc - j >= 0 && ex_fv[(cyc - j) % 64]) eb = 1;
        chk("busy", bus.o_busy, eb);
`ifdef FPU_SCHED_PERF_EN
        chk("issue_cnt", issue_cnt, m_iss);
        chk("stall_cnt", stall_cnt, m_stl);
        if (k >= 0) m_iss++;
        if ((bus.i_req_valid & ~eg) != '0) m_stl++;
`endif
        ex_rv[s] = '0;
        n = (cyc + 1) % 64;
        ex_fv[n] = (k >= 0);
        if (k >= 0) begin
          ex_fa[n] = bus.i_req_a[k];
          ex_fb[n] = bus.i_req_b[k];
          ex_fs[n] = bus.i_req_sub[k];
          r = (cyc + 2 + LAT) % 64;
          ex_rv[r] = eg;
          ex_rd[r] = fmod(bus.i_req_a[k], bus.i_req_b[k], bus.i_req_sub[k]);
          m_ptr = (k + 1) % NR;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NR-1:0] g3 [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};

  initial begin
    rst = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_req_sub   = '0;
    repeat (2) tick();
    #2;
    chk("init_busy", bus.o_busy, 0);
    chk("init_rsp_valid", bus.o_rsp_valid, 0);
    tick();
    rst = 1'b0;

    // Single op from requester 0: 1.0 + 2.0
    tick();
    bus.i_req_valid = 4'b0001;
    bus.i_req_a[0]  = 32'h3F80_0000;
    bus.i_req_b[0]  = 32'h4000_0000;
    bus.i_req_sub[0] = 1'b0;
    #2 chk("t2_ready", bus.o_req_ready, 4'b0001);
    tick();
    bus.i_req_valid = '0;
    #2;
    chk("t2_fpu_valid", bus.o_fpu_valid, 1);
    chk("t2_fpu_a", bus.o_fpu_a, 32'h3F80_0000);
    chk("t2_fpu_b", bus.o_fpu_b, 32'h4000_0000);
    repeat (LAT + 1) tick();
    #2;
    chk("t2_rsp_valid", bus.o_rsp_valid, 4'b0001);
    chk("t2_rsp_data", bus.o_rsp_data, 32'h4040_0000);
    repeat (2) tick();

    // Reset in the middle of a stream of ops
    for (int i = 0; i < NR; i++) begin
      bus.i_req_a[i] = 32'h1000_0000 * (i + 1);
      bus.i_req_b[i] = 32'h0000_0101 * (i + 3);
    end
    bus.i_req_valid = 4'b1111;
    repeat (3) tick();
    rst = 1'b1;
    #2;
    chk("t1_ready", bus.o_req_ready, 0);
    chk("t1_fpu_valid", bus.o_fpu_valid, 0);
    chk("t1_rsp_valid", bus.o_rsp_valid, 0);
    chk("t1_busy", bus.o_busy, 0);
    tick();
    rst = 1'b0;
    bus.i_req_valid = '0;
    for (int i = 0; i < LAT + 3; i++) begin
      #2 chk("t1_stale_rsp", bus.o_rsp_valid, 0);
      tick();
    end

    // All four held: strict rotation from pointer 0
    bus.i_req_valid = 4'b1111;
    bus.i_req_sub   = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      #2 chk("t3_rr_seq", bus.o_req_ready, g3[i]);
      tick();
    end
    bus.i_req_valid = '0;
    repeat (LAT + 3) tick();

    // Wrap: 3 then 0, after which the pointer sits at 1
    bus.i_req_valid = 4'b1000;
    #2 chk("t4_grant3", bus.o_req_ready, 4'b1000);
    tick();
    bus.i_req_valid = 4'b0001;
    #2 chk("t4_grant0", bus.o_req_ready, 4'b0001);
    tick();
    bus.i_req_valid = 4'b0011;
    #2 chk("t4_ptr1", bus.o_req_ready, 4'b0010);
    tick();
    bus.i_req_valid = '0;
    repeat (LAT + 3) tick();

    // Sparse traffic with idle cycles
    for (int c = 0; c < 80; c++) begin
      bus.i_req_valid = (c % 3 == 2) ? 4'b0000 : NR'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) begin
        bus.i_req_a[i] = $urandom;
        bus.i_req_b[i] = $urandom;
      end
      bus.i_req_sub = NR'($urandom_range(0, 15));
      tick();
    end
    bus.i_req_valid = '0;
    repeat (LAT + 3) tick();

`ifdef FPU_SCHED_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.i_req_valid = 4'b0011;
    repeat (3) tick();
    bus.i_req_valid = '0;
    #2;
    chk("t6_issue_cnt", issue_cnt, 3);
    chk("t6_stall_cnt", stall_cnt, 3);
    repeat (LAT + 3) tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
